// File: rtl/seq_divider_32.sv
// Purpose: multi-cycle signed non-restoring divider, result packed as {remainder, quotient}.
// Latency: done pulses WIDTH+2 edges after the accepting edge (counting it); one edge for divide-by-zero.
// Backpressure: start is only taken in IDLE or DONE; start while busy is dropped with no side effects.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Partial remainder carries one extra sign bit so add/sub never overflows.
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic             can_start;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] rem_out;
    logic [WIDTH-1:0] quo_out;

    // Operand magnitudes and one non-restoring step; 0x80..0 maps to unsigned 2^(W-1).
    always_comb begin
        can_start    = start && (state == S_IDLE || state == S_DONE);
        divisor_zero = (divisor == '0);
        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
        rem_sh       = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_step     = rem[WIDTH] ? (rem_sh + {1'b0, dvs}) : (rem_sh - {1'b0, dvs});
        quo_sh       = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
        // Restored remainder lies in [0, D), so the low W bits are exact.
        rem_fix      = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
        rem_out      = sign_r ? -rem_fix : rem_fix;
        quo_out      = sign_q ? -quo : quo;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = divisor_zero ? S_DONE : S_CALC;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (can_start) begin
                        if (divisor_zero) begin
                            result      <= {dividend, {WIDTH{1'b1}}};
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            quo    <= dividend_mag;
                            dvs    <= divisor_mag;
                            rem    <= '0;
                            cnt    <= '0;
                            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r <= dividend[WIDTH-1];
                            busy   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_step;
                    quo <= quo_sh;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    result <= {rem_out, quo_out};
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit signed arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint      la;
        longint      lb;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = la / lb;
        r  = la % lb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Issue one operation and watch it to completion (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output logic dbz,
                          output int lat, output int bcnt, output logic done_after);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = 1;
        bcnt = 0;
        res  = '0;
        dbz  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                res = result;
                dbz = div_by_zero;
                break;
            end
            lat++;
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
            n_err++;
            $display("FAIL reset: busy/done/dbz=%b%b%b result=%h want 000 and 0", busy, done, div_by_zero, result);
        end
        clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_basic;
        logic [63:0] res; logic dbz; int lat; int bcnt; logic da;
        run_op(32'd100, 32'd7, res, dbz, lat, bcnt, da);
        n_cmp++;
        if (res !== 64'h00000002_0000000E) begin n_err++; $display("FAIL basic_result: got %h want %h", res, 64'h00000002_0000000E); end
        n_cmp++;
        if (dbz !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", dbz); end
        n_cmp++;
        if (lat !== 34) begin n_err++; $display("FAIL basic_latency: got %0d want 34", lat); end
        n_cmp++;
        if (bcnt !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", bcnt); end
        n_cmp++;
        if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: done still %b a cycle later, want 0", da); end
    endtask

    task automatic test_signs;
        logic [31:0] av[6] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000, 32'h7FFFFFFF, 32'd0};
        logic [31:0] bv[6] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1, 32'd5};
        logic [63:0] ev[6] = '{64'hFFFFFFFE_FFFFFFF2, 64'h00000002_FFFFFFF2, 64'hFFFFFFFE_0000000E,
                               64'h00000000_80000000, 64'h00000000_7FFFFFFF, 64'd0};
        logic [63:0] res; logic dbz; int lat; int bcnt; logic da;
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], res, dbz, lat, bcnt, da);
            n_cmp++;
            if (res !== ev[i] || dbz !== 1'b0) begin
                n_err++;
                $display("FAIL signs[%0d] %h/%h: got %h dbz=%b want %h dbz=0", i, av[i], bv[i], res, dbz, ev[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [63:0] res; logic dbz; int lat; int bcnt; logic da;
        run_op(32'd7, 32'd0, res, dbz, lat, bcnt, da);
        n_cmp++;
        if (res !== 64'h00000007_FFFFFFFF) begin n_err++; $display("FAIL dz_result: got %h want %h", res, 64'h00000007_FFFFFFFF); end
        n_cmp++;
        if (dbz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", dbz); end
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++;
        if (bcnt !== 0) begin n_err++; $display("FAIL dz_busy: busy seen %0d cycles want 0", bcnt); end
        n_cmp++;
        if (da !== 1'b0 || div_by_zero !== 1'b0) begin
            n_err++; $display("FAIL dz_pulse: done=%b dbz=%b a cycle later, want 0 0", da, div_by_zero);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        logic [63:0] res; logic dbz; int lat; int bcnt; logic da;
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 9; i++) begin @(negedge clk); if (done) dones++; end
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 9; i++) begin @(negedge clk); if (done) dones++; end
        clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
            n_err++;
            $display("FAIL abort_clear: busy/done/dbz=%b%b%b result=%h want 000 and 0", busy, done, div_by_zero, result);
        end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) dones++; end
        n_cmp++;
        if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: saw %0d done pulses want 0", dones); end
        run_op(32'd9, 32'd3, res, dbz, lat, bcnt, da);
        n_cmp++;
        if (res !== 64'h00000000_00000003 || lat !== 34) begin
            n_err++; $display("FAIL abort_after: got %h lat %0d want %h lat 34", res, lat, 64'h3);
        end
    endtask

    task automatic test_back_to_back;
        int t_first = -1;
        int t_second = -1;
        logic [63:0] r1 = '0;
        logic [63:0] r2 = '0;
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd8;
        @(posedge clk); #1;
        dividend = 32'd13; divisor = 32'd4;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done) begin
                if (t_first < 0) begin
                    t_first = c; r1 = result;
                end else begin
                    t_second = c; r2 = result;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (r1 !== 64'h00000002_00000006) begin n_err++; $display("FAIL b2b_first: got %h want %h", r1, 64'h00000002_00000006); end
        n_cmp++;
        if (r2 !== 64'h00000001_00000003) begin n_err++; $display("FAIL b2b_second: got %h want %h", r2, 64'h00000001_00000003); end
        n_cmp++;
        if (t_first < 0 || t_second - t_first !== 34) begin
            n_err++; $display("FAIL b2b_spacing: done at %0d and %0d want 34 apart", t_first, t_second);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        logic [63:0] res; logic dbz; int lat; int bcnt; logic da;
        logic [31:0] a; logic [31:0] b; logic [63:0] exp_r; logic exp_z; int exp_lat;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom_range(1, 15);
                1:       b = -$urandom_range(1, 15);
                2:       b = (i % 7 == 0) ? 32'd0 : $urandom;
                3:       b = {1'b1, 31'd0};
                default: b = $urandom;
            endcase
            if (i % 11 == 0) a = 32'h80000000;
            exp_r   = ref_div(a, b);
            exp_z   = (b == 32'd0);
            exp_lat = exp_z ? 1 : 34;
            run_op(a, b, res, dbz, lat, bcnt, da);
            n_cmp++;
            if (res !== exp_r || dbz !== exp_z || lat !== exp_lat) begin
                n_err++;
                $display("FAIL random[%0d] %h/%h: got %h dbz=%b lat=%0d want %h dbz=%b lat=%0d",
                         i, a, b, res, dbz, lat, exp_r, exp_z, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
